// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state register and round counter,
// fetches round keys over req/ack and steps an external combinational round datapath.
module aes_round_ctrl #(
  parameter int unsigned WData   = 128,
  parameter int unsigned NRounds = 10,
  parameter int unsigned WRnd    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WData-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WData-1:0] out_data_o,
  output logic             rk_req_o,
  output logic [WRnd-1:0]  rk_idx_o,
  input  logic             rk_ack_i,
  input  logic [WData-1:0] rk_data_i,
  output logic [WData-1:0] dp_state_o,
  output logic [WData-1:0] dp_key_o,
  output logic             dp_last_o,
  input  logic [WData-1:0] dp_result_i,
  output logic             busy_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StKey   = 2'd1;
  localparam logic [1:0] StRound = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [WRnd-1:0] LastRnd = WRnd'(NRounds);

  logic [1:0]       fsm_q, fsm_d;
  logic [WData-1:0] state_q, state_d;
  logic [WData-1:0] key_q, key_d;
  logic [WRnd-1:0]  rnd_q, rnd_d;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = in_data_i;
          rnd_d   = '0;
          fsm_d   = StKey;
        end
      end
      StKey: begin
        if (rk_ack_i) begin
          // Key 0 is the whitening key and is applied here directly, not via the datapath.
          if (rnd_q == '0) begin
            state_d = state_q ^ rk_data_i;
            rnd_d   = rnd_q + WRnd'(1);
          end else begin
            key_d = rk_data_i;
            fsm_d = StRound;
          end
        end
      end
      StRound: begin
        state_d = dp_result_i;
        if (rnd_q == LastRnd) begin
          fsm_d = StDone;
        end else begin
          rnd_d = rnd_q + WRnd'(1);
          fsm_d = StKey;
        end
      end
      StDone: begin
        if (out_ready_i) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready_o  = (fsm_q == StIdle);
  assign out_valid_o = (fsm_q == StDone);
  assign rk_req_o    = (fsm_q == StKey);
  assign dp_last_o   = (fsm_q == StRound) && (rnd_q == LastRnd);
  assign busy_o      = (fsm_q != StIdle);
  assign rk_idx_o    = rnd_q;
  assign out_data_o  = state_q;
  assign dp_state_o  = state_q;
  assign dp_key_o    = key_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with a behavioural AES round datapath and
// key-schedule responder; expected ciphertexts come from a plain AES-128 model.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data, rk_data, dp_state, dp_key, dp_result;
  logic         rk_req, rk_ack, dp_last, busy;
  logic [3:0]   rk_idx;

  aes_round_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .rk_req_o    (rk_req),
    .rk_idx_o    (rk_idx),
    .rk_ack_i    (rk_ack),
    .rk_data_i   (rk_data),
    .dp_state_o  (dp_state),
    .dp_key_o    (dp_key),
    .dp_last_o   (dp_last),
    .dp_result_i (dp_result),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y = x;
    logic [7:0] v = 8'h01;
    if (x == 8'h00) return 8'h63;
    for (int i = 1; i < 8; i++) begin
      y = gm(y, y);
      v = gm(v, y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[4*c+rw] = b[4*((c+rw)%4)+rw];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
        t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int idx);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s = pt ^ round_key(key, 0);
    for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(key, r), r == 10);
    return s;
  endfunction

  // ---------------- environment: datapath and key schedule ----------------
  logic [127:0] cur_key, nxt_key, spur_data;
  int           cur_wait, nxt_wait, wcnt;
  logic         spur, spur_en;

  assign dp_result = aes_round(dp_state, dp_key, dp_last);
  assign rk_ack    = rk_req ? (wcnt >= cur_wait) : spur;
  assign rk_data   = rk_req ? round_key(cur_key, int'(rk_idx)) : spur_data;

  always @(posedge clk) begin
    wcnt      <= (rk_req && !rk_ack) ? wcnt + 1 : 0;
    spur      <= spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
    spur_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  logic or_rand, or_fixed;
  always @(posedge clk) begin
    #1;
    out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_fixed;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [127:0] ct;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           acc_cyc, last_acc, exp_idx, dl_cnt;
  logic         inflight, have_acc, ov_prev, or_prev;
  logic [127:0] od_prev, last_ct;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      inflight = 1'b0;
      have_acc = 1'b0;
      ov_prev  = 1'b0;
      or_prev  = 1'b0;
    end else begin
      chk("busy", 128'(busy), 128'(inflight));
      if (rk_req) chk("rk_idx", 128'(rk_idx), 128'(exp_idx));
      if (rk_req && rk_ack) exp_idx++;
      if (dp_last) begin
        dl_cnt++;
        chk("dp_last_rnd", 128'(rk_idx), 128'd10);
      end
      if (out_valid) begin
        chk("in_ready_done", 128'(in_ready), 128'd0);
        if (!ov_prev) begin
          if (exp_q.size() == 0) chk("unexpected_out", 128'd1, 128'd0);
          else chk("latency", 128'(cyc - acc_cyc), 128'(exp_q[0].lat));
        end else if (!or_prev) begin
          chk("out_hold", out_data, od_prev);
        end
        if (out_ready && exp_q.size() != 0) begin
          chk("ciphertext", out_data, exp_q[0].ct);
          chk("key_count", 128'(exp_idx), 128'd11);
          chk("dp_last_count", 128'(dl_cnt), 128'd1);
          last_ct = out_data;
          void'(exp_q.pop_front());
          inflight = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        chk("accept_idle", 128'(inflight), 128'd0);
        if (have_acc) chk("accept_gap_ge23", 128'(cyc - last_acc >= 23), 128'd1);
        exp_q.push_back('{ct: aes_encrypt(nxt_key, in_data), lat: 22 + 11 * nxt_wait});
        cur_key  = nxt_key;
        cur_wait = nxt_wait;
        acc_cyc  = cyc;
        last_acc = cyc;
        have_acc = 1'b1;
        inflight = 1'b1;
        exp_idx  = 0;
        dl_cnt   = 0;
      end
      ov_prev = out_valid;
      or_prev = out_ready;
      od_prev = out_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] key, input logic [127:0] pt, input int wt,
                      input logic keep);
    logic got = 1'b0;
    @(posedge clk); #2;
    nxt_key  = key;
    nxt_wait = wt;
    in_data  = pt;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 128'd1, 128'd0);
    @(posedge clk); #2;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!inflight && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 128'd1, 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    logic         seen;
    rst_ni = 1'b0; in_valid = 1'b0; in_data = '0;
    or_rand = 1'b0; or_fixed = 1'b1; spur_en = 1'b0;
    nxt_key = '0; nxt_wait = 0; cur_key = '0; cur_wait = 0;
    inflight = 1'b0; exp_idx = 0; dl_cnt = 0; last_ct = '0;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_rk_req", 128'(rk_req), 128'd0);
    chk("rst_dp_last", 128'(dp_last), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_dp_key", dp_key, 128'd0);

    // FIPS-197 App. B, zero-wait keys
    send(K1, P1, 0, 1'b0);
    wait_idle();
    chk("fips_b_ct", last_ct, C1);

    // FIPS-197 C.1, three wait cycles per key request
    send(K2, P2, 3, 1'b0);
    wait_idle();
    chk("fips_c1_ct", last_ct, C2);

    // Backpressure in DONE with in_valid pulsed
    or_fixed = 1'b0;
    send(K1, P1, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_reach_done", 128'(seen), 128'd1);
    held = out_data;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    or_fixed = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_release", 128'(seen), 128'd1);
    @(negedge clk);
    chk("bp_idle_in_ready", 128'(in_ready), 128'd1);
    chk("bp_idle_busy", 128'(busy), 128'd0);
    chk("bp_ct", last_ct, C1);

    // Reset while round 5 key is being fetched
    spur_en = 1'b1;
    send(K1, P1, 2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rk_req && rk_idx == 4'd5) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_reach", 128'(seen), 128'd1);
    @(posedge clk); #2 rst_ni = 1'b0;
    @(posedge clk); #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_rk_req", 128'(rk_req), 128'd0);
    send(K1, P1, 0, 1'b0);
    wait_idle();
    chk("post_rst_ct", last_ct, C1);

    // Back-to-back with in_valid held and spurious acks outside KEY
    send(K1, P1, 0, 1'b1);
    send(K2, P2, 3, 1'b0);
    wait_idle();
    chk("b2b_second_ct", last_ct, C2);

    // Randomized blocks, waits and backpressure
    or_rand = 1'b1;
    for (int n = 0; n < 16; n++)
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    @(posedge clk); #2;
    in_valid = 1'b0;
    or_rand  = 1'b0;
    wait_idle();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
